// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the data-side load/store unit: funct3 codes,
// FSM state encoding and the misalignment rule.
package load_store_unit_pkg;

   localparam logic [2:0] MEM_FUNCT_B  = 3'd0;
   localparam logic [2:0] MEM_FUNCT_H  = 3'd1;
   localparam logic [2:0] MEM_FUNCT_W  = 3'd2;
   localparam logic [2:0] MEM_FUNCT_BU = 3'd4;
   localparam logic [2:0] MEM_FUNCT_HU = 3'd5;

   localparam int LSU_STATE_W = 3;
   localparam int STRB_W      = 4;

   typedef enum logic [LSU_STATE_W-1:0] {
      LSU_IDLE    = 3'd0,
      LSU_RD_ADDR = 3'd1,
      LSU_RD_DATA = 3'd2,
      LSU_WR_REQ  = 3'd3,
      LSU_WR_RESP = 3'd4,
      LSU_DONE    = 3'd5
   } lsu_state_t;

   // Halfwords need an even offset, words (and unused codes) need offset 0.
   function automatic logic is_misaligned(input logic [2:0] funct, input logic [1:0] off);
      logic mis;
      case (funct)
         MEM_FUNCT_B, MEM_FUNCT_BU: mis = 1'b0;
         MEM_FUNCT_H, MEM_FUNCT_HU: mis = off[0];
         default:                   mis = (off != 2'd0);
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/load_store_unit_lsu_load_align.sv
// Combinational load formatter: lane-shifts the bus word by the byte offset
// and applies sign/zero extension for the access size.
module lsu_load_align
   import load_store_unit_pkg::*;
(
   input  logic [31:0] dr_data,
   input  logic [1:0]  off,
   input  logic [2:0]  funct,
   output logic [31:0] result
);

   logic [31:0] shifted_s;

   // Halfwords shift by whole halves so a misaligned H still reads a lane pair.
   always_comb begin
      shifted_s = 32'h0;
      result    = 32'h0;
      if (funct == MEM_FUNCT_H || funct == MEM_FUNCT_HU) begin
         shifted_s = dr_data >> {off[1], 4'b0000};
      end else begin
         shifted_s = dr_data >> {off, 3'b000};
      end
      case (funct)
         MEM_FUNCT_B:  result = {{24{shifted_s[7]}}, shifted_s[7:0]};
         MEM_FUNCT_BU: result = {24'h0, shifted_s[7:0]};
         MEM_FUNCT_H:  result = {{16{shifted_s[15]}}, shifted_s[15:0]};
         MEM_FUNCT_HU: result = {16'h0, shifted_s[15:0]};
         default:      result = shifted_s;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Data-side bus master: turns single-cycle load/store pulses into read or
// write handshakes and returns a one-cycle completion with formatted data.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_data,
   input  logic                  store_data,
   input  logic [2:0]            mem_funct,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] store_wdata,
   output logic                  data_valid,
   output logic [DATA_WIDTH-1:0] load_rdata,
   output logic                  misaligned,
   output logic                  busy,
   output logic                  dr_addr_valid,
   input  logic                  dr_addr_ready,
   output logic [ADDR_WIDTH-1:0] dr_addr,
   input  logic                  dr_data_valid,
   output logic                  dr_data_ready,
   input  logic [DATA_WIDTH-1:0] dr_data,
   output logic                  dw_valid,
   input  logic                  dw_ready,
   output logic [ADDR_WIDTH-1:0] dw_addr,
   output logic [DATA_WIDTH-1:0] dw_data,
   output logic [STRB_W-1:0]     dw_strobe,
   input  logic                  dw_resp_valid,
   output logic                  dw_resp_ready
);

   lsu_state_t            state_r;
   logic [2:0]            funct_r;
   logic [1:0]            off_r;
   logic                  mis_r;
   logic [DATA_WIDTH-1:0] st_data_s;
   logic [STRB_W-1:0]     st_strb_s;
   logic [DATA_WIDTH-1:0] aligned_s;

   lsu_load_align u_align (
      .dr_data (dr_data),
      .off     (off_r),
      .funct   (funct_r),
      .result  (aligned_s)
   );

   // Store lane replication and strobes, taken from the live request inputs.
   always_comb begin
      st_data_s = store_wdata;
      st_strb_s = 4'hF;
      case (mem_funct)
         MEM_FUNCT_B: begin
            st_data_s = {4{store_wdata[7:0]}};
            st_strb_s = 4'b0001 << mem_addr[1:0];
         end
         MEM_FUNCT_H: begin
            st_data_s = {2{store_wdata[15:0]}};
            st_strb_s = 4'b0011 << {mem_addr[1], 1'b0};
         end
         default: begin
            st_data_s = store_wdata;
            st_strb_s = 4'hF;
         end
      endcase
   end

   // Transaction FSM; every output is a register so bus payloads stay stable.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r       <= LSU_IDLE;
         funct_r       <= 3'd0;
         off_r         <= 2'd0;
         mis_r         <= 1'b0;
         data_valid    <= 1'b0;
         load_rdata    <= '0;
         misaligned    <= 1'b0;
         busy          <= 1'b0;
         dr_addr_valid <= 1'b0;
         dr_addr       <= '0;
         dr_data_ready <= 1'b0;
         dw_valid      <= 1'b0;
         dw_addr       <= '0;
         dw_data       <= '0;
         dw_strobe     <= 4'h0;
         dw_resp_ready <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         misaligned <= 1'b0;
         case (state_r)
            LSU_IDLE: begin
               if (load_data) begin
                  funct_r       <= mem_funct;
                  off_r         <= mem_addr[1:0];
                  mis_r         <= is_misaligned(mem_funct, mem_addr[1:0]);
                  dr_addr       <= {mem_addr[ADDR_WIDTH-1:2], 2'b00};
                  dr_addr_valid <= 1'b1;
                  busy          <= 1'b1;
                  state_r       <= LSU_RD_ADDR;
               end else if (store_data) begin
                  funct_r   <= mem_funct;
                  off_r     <= mem_addr[1:0];
                  mis_r     <= is_misaligned(mem_funct, mem_addr[1:0]);
                  dw_addr   <= {mem_addr[ADDR_WIDTH-1:2], 2'b00};
                  dw_data   <= st_data_s;
                  dw_strobe <= st_strb_s;
                  dw_valid  <= 1'b1;
                  busy      <= 1'b1;
                  state_r   <= LSU_WR_REQ;
               end
            end
            LSU_RD_ADDR: begin
               if (dr_addr_valid && dr_addr_ready) begin
                  dr_addr_valid <= 1'b0;
                  dr_data_ready <= 1'b1;
                  state_r       <= LSU_RD_DATA;
               end
            end
            LSU_RD_DATA: begin
               if (dr_data_valid && dr_data_ready) begin
                  dr_data_ready <= 1'b0;
                  load_rdata    <= aligned_s;
                  data_valid    <= 1'b1;
                  misaligned    <= mis_r;
                  state_r       <= LSU_DONE;
               end
            end
            LSU_WR_REQ: begin
               if (dw_valid && dw_ready) begin
                  dw_valid      <= 1'b0;
                  dw_resp_ready <= 1'b1;
                  state_r       <= LSU_WR_RESP;
               end
            end
            LSU_WR_RESP: begin
               if (dw_resp_valid) begin
                  dw_resp_ready <= 1'b0;
                  data_valid    <= 1'b1;
                  misaligned    <= mis_r;
                  state_r       <= LSU_DONE;
               end
            end
            LSU_DONE: begin
               busy    <= 1'b0;
               state_r <= LSU_IDLE;
            end
            default: begin
               dr_addr_valid <= 1'b0;
               dr_data_ready <= 1'b0;
               dw_valid      <= 1'b0;
               dw_resp_ready <= 1'b0;
               busy          <= 1'b0;
               state_r       <= LSU_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a table of zero-wait transactions plus
// hand-written back-pressure, arbitration and mid-transaction reset sequences.
module tb_load_store_unit;
   import load_store_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_data, store_data;
   logic [2:0]  mem_funct;
   logic [31:0] mem_addr, store_wdata;
   logic        data_valid, misaligned, busy;
   logic [31:0] load_rdata;
   logic        dr_addr_valid, dr_addr_ready, dr_data_valid, dr_data_ready;
   logic [31:0] dr_addr, dr_data;
   logic        dw_valid, dw_ready, dw_resp_valid, dw_resp_ready;
   logic [31:0] dw_addr, dw_data;
   logic [3:0]  dw_strobe;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .load_data(load_data), .store_data(store_data),
      .mem_funct(mem_funct), .mem_addr(mem_addr), .store_wdata(store_wdata),
      .data_valid(data_valid), .load_rdata(load_rdata), .misaligned(misaligned),
      .busy(busy), .dr_addr_valid(dr_addr_valid), .dr_addr_ready(dr_addr_ready),
      .dr_addr(dr_addr), .dr_data_valid(dr_data_valid), .dr_data_ready(dr_data_ready),
      .dr_data(dr_data), .dw_valid(dw_valid), .dw_ready(dw_ready), .dw_addr(dw_addr),
      .dw_data(dw_data), .dw_strobe(dw_strobe), .dw_resp_valid(dw_resp_valid),
      .dw_resp_ready(dw_resp_ready)
   );

   typedef struct {
      logic        is_load;
      logic [2:0]  funct;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] word;
      logic [31:0] exp_rdata;
      logic [31:0] exp_addr;
      logic [31:0] exp_wdata;
      logic [3:0]  exp_strb;
      logic        exp_mis;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0]  = '{1'b1, MEM_FUNCT_W,  32'h100, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 32'h100, 32'h0,        4'h0,    1'b0};
      vecs[1]  = '{1'b1, MEM_FUNCT_B,  32'h103, 32'h0,        32'h80FF1234, 32'hFFFFFF80, 32'h100, 32'h0,        4'h0,    1'b0};
      vecs[2]  = '{1'b1, MEM_FUNCT_BU, 32'h103, 32'h0,        32'h80FF1234, 32'h00000080, 32'h100, 32'h0,        4'h0,    1'b0};
      vecs[3]  = '{1'b1, MEM_FUNCT_H,  32'h102, 32'h0,        32'h80FF1234, 32'hFFFF80FF, 32'h100, 32'h0,        4'h0,    1'b0};
      vecs[4]  = '{1'b1, MEM_FUNCT_HU, 32'h102, 32'h0,        32'h80FF1234, 32'h000080FF, 32'h100, 32'h0,        4'h0,    1'b0};
      vecs[5]  = '{1'b1, MEM_FUNCT_B,  32'h101, 32'h0,        32'h80FF1234, 32'h00000012, 32'h100, 32'h0,        4'h0,    1'b0};
      vecs[6]  = '{1'b1, MEM_FUNCT_H,  32'h101, 32'h0,        32'h80FF1234, 32'h00001234, 32'h100, 32'h0,        4'h0,    1'b1};
      vecs[7]  = '{1'b1, MEM_FUNCT_W,  32'h102, 32'h0,        32'hDEADBEEF, 32'h0000DEAD, 32'h100, 32'h0,        4'h0,    1'b1};
      vecs[8]  = '{1'b1, 3'd3,         32'h104, 32'h0,        32'hCAFEF00D, 32'hCAFEF00D, 32'h104, 32'h0,        4'h0,    1'b0};
      vecs[9]  = '{1'b0, MEM_FUNCT_B,  32'h301, 32'h00000055, 32'h0,        32'h0,        32'h300, 32'h55555555, 4'b0010, 1'b0};
      vecs[10] = '{1'b0, MEM_FUNCT_W,  32'h400, 32'h12345678, 32'h0,        32'h0,        32'h400, 32'h12345678, 4'b1111, 1'b0};
      vecs[11] = '{1'b0, MEM_FUNCT_H,  32'h200, 32'hFFFF1111, 32'h0,        32'h0,        32'h200, 32'h11111111, 4'b0011, 1'b0};
      vecs[12] = '{1'b0, MEM_FUNCT_W,  32'h402, 32'hA5A5_0F0F, 32'h0,       32'h0,        32'h400, 32'hA5A50F0F, 4'b1111, 1'b1};
      vecs[13] = '{1'b0, 3'd6,         32'h501, 32'h01020304, 32'h0,        32'h0,        32'h500, 32'h01020304, 4'b1111, 1'b1};

      rst = 1'b0; load_data = 1'b0; store_data = 1'b0; mem_funct = 3'd0;
      mem_addr = 32'h0; store_wdata = 32'h0; dr_addr_ready = 1'b0;
      dr_data_valid = 1'b0; dr_data = 32'h0; dw_ready = 1'b0; dw_resp_valid = 1'b0;
      tick; tick;
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_data_valid", {31'h0, data_valid}, 32'h0);
      chk("rst_valids", {28'h0, dr_addr_valid, dr_data_ready, dw_valid, dw_resp_ready}, 32'h0);
      chk("rst_strobe", {28'h0, dw_strobe}, 32'h0);
      chk("rst_load_rdata", load_rdata, 32'h0);
      chk("rst_misaligned", {31'h0, misaligned}, 32'h0);
      rst = 1'b1;
      tick;

      // Zero-wait slave for the table: readies and response/data valids held high.
      dr_addr_ready = 1'b1; dr_data_valid = 1'b1; dw_ready = 1'b1; dw_resp_valid = 1'b1;
      for (int i = 0; i < 14; i++) begin
         mem_funct = vecs[i].funct; mem_addr = vecs[i].addr; store_wdata = vecs[i].wdata;
         dr_data = vecs[i].word;
         load_data = vecs[i].is_load; store_data = ~vecs[i].is_load;
         tick;
         load_data = 1'b0; store_data = 1'b0;
         mem_addr = 32'hFFFF_FFFF; mem_funct = 3'd7; store_wdata = 32'h0;
         if (vecs[i].is_load) begin
            chk($sformatf("v%0d_rd_addr_valid", i), {31'h0, dr_addr_valid}, 32'h1);
            chk($sformatf("v%0d_rd_addr", i), dr_addr, vecs[i].exp_addr);
            chk($sformatf("v%0d_no_dw_valid", i), {31'h0, dw_valid}, 32'h0);
         end else begin
            chk($sformatf("v%0d_dw_valid", i), {31'h0, dw_valid}, 32'h1);
            chk($sformatf("v%0d_dw_addr", i), dw_addr, vecs[i].exp_addr);
            chk($sformatf("v%0d_dw_data", i), dw_data, vecs[i].exp_wdata);
            chk($sformatf("v%0d_dw_strobe", i), {28'h0, dw_strobe}, {28'h0, vecs[i].exp_strb});
            chk($sformatf("v%0d_no_rd_valid", i), {31'h0, dr_addr_valid}, 32'h0);
         end
         tick;
         chk($sformatf("v%0d_ready2", i), {30'h0, dr_data_ready, dw_resp_ready},
             vecs[i].is_load ? 32'h2 : 32'h1);
         chk($sformatf("v%0d_early_dv", i), {31'h0, data_valid}, 32'h0);
         tick;
         chk($sformatf("v%0d_data_valid", i), {31'h0, data_valid}, 32'h1);
         chk($sformatf("v%0d_misaligned", i), {31'h0, misaligned}, {31'h0, vecs[i].exp_mis});
         chk($sformatf("v%0d_busy_done", i), {31'h0, busy}, 32'h1);
         if (vecs[i].is_load) chk($sformatf("v%0d_load_rdata", i), load_rdata, vecs[i].exp_rdata);
         tick;
         chk($sformatf("v%0d_idle", i), {29'h0, busy, data_valid, misaligned}, 32'h0);
      end

      // SH with write back-pressure and an ignored store pulse while busy.
      dw_ready = 1'b0; dw_resp_valid = 1'b0;
      mem_funct = MEM_FUNCT_H; mem_addr = 32'h202; store_wdata = 32'h0000ABCD; store_data = 1'b1;
      tick;
      store_data = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("sh_hold%0d_valid", k), {31'h0, dw_valid}, 32'h1);
         chk($sformatf("sh_hold%0d_addr", k), dw_addr, 32'h200);
         chk($sformatf("sh_hold%0d_data", k), dw_data, 32'hABCDABCD);
         chk($sformatf("sh_hold%0d_strobe", k), {28'h0, dw_strobe}, 32'hC);
         if (k == 1) begin
            mem_funct = MEM_FUNCT_B; mem_addr = 32'h301; store_wdata = 32'h55; store_data = 1'b1;
         end
         tick;
         store_data = 1'b0;
      end
      dw_ready = 1'b1;
      tick;
      dw_ready = 1'b0;
      chk("sh_resp_wait", {30'h0, dw_valid, dw_resp_ready}, 32'h1);
      tick;
      chk("sh_no_early_dv", {31'h0, data_valid}, 32'h0);
      dw_resp_valid = 1'b1;
      tick;
      dw_resp_valid = 1'b0;
      chk("sh_data_valid", {31'h0, data_valid}, 32'h1);
      chk("sh_not_misaligned", {31'h0, misaligned}, 32'h0);
      tick;
      chk("sh_idle", {30'h0, busy, dw_valid}, 32'h0);
      tick;
      chk("sh_dropped_store", {30'h0, busy, dw_valid}, 32'h0);

      // Simultaneous load and store: the load wins, no write channel activity.
      dw_ready = 1'b1; dr_addr_ready = 1'b1; dr_data_valid = 1'b1; dr_data = 32'h11223344;
      mem_funct = MEM_FUNCT_W; mem_addr = 32'h108; store_wdata = 32'h99999999;
      load_data = 1'b1; store_data = 1'b1;
      tick;
      load_data = 1'b0; store_data = 1'b0;
      chk("both_rd_only", {30'h0, dr_addr_valid, dw_valid}, 32'h2);
      chk("both_rd_addr", dr_addr, 32'h108);
      tick;
      chk("both_rd_data", {30'h0, dr_data_ready, dw_valid}, 32'h2);
      tick;
      chk("both_done", {30'h0, data_valid, dw_resp_ready}, 32'h2);
      chk("both_rdata", load_rdata, 32'h11223344);
      tick;
      chk("both_idle", {30'h0, busy, dw_valid}, 32'h0);

      // Reset while waiting in RD_DATA; the late read data must be ignored.
      dr_data_valid = 1'b0; dr_data = 32'h77777777;
      mem_funct = MEM_FUNCT_W; mem_addr = 32'h100; load_data = 1'b1;
      tick;
      load_data = 1'b0;
      tick;
      chk("rstmid_in_rd_data", {30'h0, busy, dr_data_ready}, 32'h3);
      rst = 1'b0;
      tick;
      rst = 1'b1;
      chk("rstmid_busy", {31'h0, busy}, 32'h0);
      chk("rstmid_valids", {28'h0, dr_addr_valid, dr_data_ready, dw_valid, dw_resp_ready}, 32'h0);
      chk("rstmid_rdata", load_rdata, 32'h0);
      dr_data_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick;
         chk($sformatf("rstmid_no_dv%0d", k), {30'h0, data_valid, busy}, 32'h0);
      end
      dr_data_valid = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
